// File: rtl/tlb_search_arbiter.sv
// Arbitrates the shared TLB search port between IF and MEM translation requests,
// runs one search at a time and checks the returned entry against access type and PLV.
module tlb_search_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ASID_W       = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_req_vaddr,
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic [31:0]       mem_req_vaddr,
  input  logic              mem_req_wr,
  input  logic [ASID_W-1:0] csr_asid,
  input  logic [1:0]        csr_plv,
  input  logic              tlb_flush,
  output logic              s_req,
  output logic [18:0]       s_vppn,
  output logic              s_va_bit12,
  output logic [ASID_W-1:0] s_asid,
  input  logic              s_found,
  input  logic [19:0]       s_ppn,
  input  logic [5:0]        s_ps,
  input  logic [1:0]        s_plv,
  input  logic [1:0]        s_mat,
  input  logic              s_d,
  input  logic              s_v,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [19:0]       resp_pfn,
  output logic [1:0]        resp_mat,
  output logic [2:0]        resp_ecode,
  output logic [1:0]        dbg_state
);

  // Handshakes: a request is taken on the clock edge where valid && ready; ready is
  // only ever high in IDLE for the granted requester. A response is consumed on the
  // edge where resp_valid && resp_ready; fields stay frozen until then.

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [2:0] EC_NONE = 3'd0;
  localparam logic [2:0] EC_TLBR = 3'd1;
  localparam logic [2:0] EC_PIL  = 3'd2;
  localparam logic [2:0] EC_PIS  = 3'd3;
  localparam logic [2:0] EC_PIF  = 3'd4;
  localparam logic [2:0] EC_PPI  = 3'd5;
  localparam logic [2:0] EC_PME  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_CHECK  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [31:12]        vaddr_q;
  logic                id_q;
  logic                wr_q;
  logic [ASID_W-1:0]   asid_q;
  logic [1:0]          plv_q;
  logic                s_req_q;
  logic                resp_valid_q;
  logic                resp_id_q;
  logic [19:0]         pfn_q, pfn_d;
  logic [1:0]          mat_q, mat_d;
  logic [2:0]          ecode_q, ecode_d;
  logic                grant_if, grant_mem;
  logic                unused_bits;

  // Grant and starvation bookkeeping; gated by resetn so nothing is offered in reset.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    starve_d  = starve_q;
    if (state_q == ST_IDLE && resetn) begin
      if (if_req_valid && starve_q == CNT_MAX) grant_if = 1'b1;
      else if (mem_req_valid)                  grant_mem = 1'b1;
      else if (if_req_valid)                   grant_if = 1'b1;
    end
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_mem) begin
      if (!if_req_valid)           starve_d = '0;
      else if (starve_q != CNT_MAX) starve_d = starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    pfn_d   = (s_ps == 6'd21) ? {s_ppn[19:9], vaddr_q[20:12]} : s_ppn;
    mat_d   = s_mat;
    ecode_d = EC_NONE;
    if (!s_found) begin
      pfn_d   = '0;
      mat_d   = '0;
      ecode_d = EC_TLBR;
    end else if (!s_v) begin
      ecode_d = !id_q ? EC_PIF : (wr_q ? EC_PIS : EC_PIL);
    end else if (plv_q > s_plv) begin
      ecode_d = EC_PPI;
    end else if (wr_q && !s_d) begin
      ecode_d = EC_PME;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      vaddr_q      <= '0;
      id_q         <= 1'b0;
      wr_q         <= 1'b0;
      asid_q       <= '0;
      plv_q        <= '0;
      s_req_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      pfn_q        <= '0;
      mat_q        <= '0;
      ecode_q      <= '0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_if || grant_mem) begin
            vaddr_q <= grant_mem ? mem_req_vaddr[31:12] : if_req_vaddr[31:12];
            id_q    <= grant_mem;
            wr_q    <= grant_mem & mem_req_wr;
            asid_q  <= csr_asid;
            plv_q   <= csr_plv;
            s_req_q <= 1'b1;
            state_q <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          s_req_q <= 1'b0;
          state_q <= tlb_flush ? ST_IDLE : ST_CHECK;
        end
        ST_CHECK: begin
          if (tlb_flush) begin
            state_q <= ST_IDLE;
          end else begin
            resp_id_q    <= id_q;
            pfn_q        <= pfn_d;
            mat_q        <= mat_d;
            ecode_q      <= ecode_d;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // A flush here is ignored: the result is already committed.
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_req_ready  = grant_if;
  assign mem_req_ready = grant_mem;
  assign s_req         = s_req_q;
  assign s_vppn        = vaddr_q[31:13];
  assign s_va_bit12    = vaddr_q[12];
  assign s_asid        = asid_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_pfn      = pfn_q;
  assign resp_mat      = mat_q;
  assign resp_ecode    = ecode_q;
  assign dbg_state     = state_q;

  assign unused_bits = ^{if_req_vaddr[11:0], mem_req_vaddr[11:0]};

endmodule

// File: doc/tlb_search_arbiter.md
Name: tlb_search_arbiter

Overview:
Shares the single TLB search port between the instruction-fetch (IF) and data-memory (MEM) translation requesters. For each request that the address translation stage routes to the TLB (DMW miss, paging mode), it performs the following steps:
- sequences the search;
- checks the returned entry against the access type and privilege;
- returns the final PFN, MAT and an exception code.

It sits between the IF/MEM translation stages and the TLB search port.

Parameters:
STARVE_LIMIT, 4, consecutive MEM grants allowed while IF is waiting before IF is forced ahead
ASID_W, 10, ASID width

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
if_req_valid  input  1  IF translation request
if_req_ready  output  1  IF request accepted this cycle
if_req_vaddr  input  32  IF virtual address
mem_req_valid  input  1  MEM translation request
mem_req_ready  output  1  MEM request accepted this cycle
mem_req_vaddr  input  32  MEM virtual address
mem_req_wr  input  1  MEM access is a store
csr_asid  input  ASID_W  current ASID
csr_plv  input  2  current privilege level
tlb_flush  input  1  abort the in-flight request (invtlb/tlbfill/ASID write)
s_req  output  1  TLB search strobe
s_vppn  output  19  search VPPN (vaddr[31:13])
s_va_bit12  output  1  vaddr[12]
s_asid  output  ASID_W  search ASID
s_found  input  1  TLB hit (valid the cycle after s_req)
s_ppn  input  20  matched PPN
s_ps  input  6  page size (12 or 21)
s_plv  input  2  entry PLV
s_mat  input  2  entry MAT
s_d  input  1  entry dirty
s_v  input  1  entry valid
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_id  output  1  0 = IF, 1 = MEM
resp_pfn  output  20  physical frame number
resp_mat  output  2  memory access type
resp_ecode  output  3  0 none, 1 TLBR, 2 PIL, 3 PIS, 4 PIF, 5 PPI, 6 PME

Behaviour:
- FSM states: IDLE -> SEARCH -> CHECK -> RESP -> IDLE. One request is in flight at a time.
- Reset (any time, asynchronous):
  - state = IDLE, starvation counter = 0;
  - all outputs are 0, including both req_ready signals, s_req and resp_valid.
- IDLE (grant and accept):
  - If any request is valid, grant one and pulse that requester's req_ready for exactly that cycle.
  - Latch vaddr, id, wr (wr is forced to 0 for IF), csr_asid and csr_plv. Go to SEARCH.
  - Both ready signals are 0 in every other state.
- Arbitration priority:
  - MEM wins by default.
  - If IF is valid and the starvation counter equals STARVE_LIMIT, IF wins.
  - The counter increments on a MEM grant while IF is valid; it saturates at STARVE_LIMIT.
  - The counter clears on any IF grant, and on a MEM grant while IF is not valid.
- SEARCH: s_req = 1 for exactly one cycle; s_vppn, s_va_bit12 and s_asid come from the latched values. Go to CHECK.
- CHECK:
  - Sample the TLB outputs and register the result. Go to RESP.
  - PFN:
    - s_ps == 21: {s_ppn[19:9], vaddr[20:12]};
    - otherwise: s_ppn.
  - resp_mat = s_mat.
  - ecode priority:
    - !s_found -> TLBR;
    - else !s_v -> PIF (IF) / PIS (store) / PIL (load);
    - else csr_plv > s_plv -> PPI;
    - else store && !s_d -> PME;
    - else 0.
  - When ecode != 0, resp_pfn and resp_mat are still driven from the entry, or are 0 if !s_found.
- RESP:
  - resp_valid = 1; the fields are held stable until the cycle in which resp_valid && resp_ready.
  - Then go to IDLE. No new grant is made in that same cycle, so the minimum issue interval is 4 cycles.
- Latency: accept at cycle t, s_req at t+1, resp_valid at t+3.
- tlb_flush:
  - In SEARCH or CHECK: return to IDLE next cycle with no response; the requester must re-issue.
  - In RESP: ignored, because the result was already committed.
  - In IDLE: no effect. A same-cycle grant still proceeds, and the flush is assumed complete.
- Simultaneous IF and MEM valid with counter < STARVE_LIMIT: MEM is granted and IF waits with valid held.

Test Plan:
1. Reset: resetn = 0 mid-SEARCH -> next edge state IDLE, s_req = 0, resp_valid = 0; after release, an IF request with vaddr 0x1C000123 is granted, s_req at t+1 with s_vppn = 0x0E000, s_va_bit12 = 0.
2. Hit, 4 KB page: MEM load vaddr 0x00402ABC; TLB returns found, ps = 12, ppn = 0x12345, v = 1, plv = 3, mat = 1, csr_plv = 3 -> resp_valid at t+3, resp_id = 1, resp_pfn = 0x12345, resp_mat = 1, ecode 0.
3. Huge page: ps = 21, ppn = 0xABC00, vaddr 0x00A5F000 -> resp_pfn = 0xABC5F.
4. Exceptions:
   - not found -> ecode 1;
   - IF with v = 0 -> 4;
   - store with v = 1, d = 0, plv ok -> 6;
   - csr_plv = 3, s_plv = 0 -> 5 (even when d = 0).
5. Arbitration: IF and MEM held valid continuously with STARVE_LIMIT = 4 -> grant sequence M, M, M, M, I, M, M, M, M, I.
6. Flush and backpressure:
   - tlb_flush in CHECK -> no resp_valid, back to IDLE, next grant possible one cycle later;
   - resp_ready held low for 5 cycles in RESP -> fields stable and no new grant until the handshake.
